// File: rtl/ifu_ibus_bridge_pkg.sv
// Shared types and constants for the fetch-side instruction bus bridge.
package ifu_ibus_bridge_pkg;

  localparam int unsigned DefaultAw = 32;
  localparam int unsigned DefaultDw = 32;

  // Canonical RISC-V nop (addi x0, x0, 0), substituted for errored words.
  localparam logic [31:0] NopWord = 32'h0000_0013;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAddr = 2'd1,
    StData = 2'd2,
    StResp = 2'd3
  } state_e;

endpackage

// File: rtl/ifu_ibus_bridge_if.sv
// Fetch-unit handshake and AR/R read bus grouped for the bridge.
interface ifu_ibus_bridge_if
  import ifu_ibus_bridge_pkg::*;
#(
  parameter int unsigned AW = DefaultAw,
  parameter int unsigned DW = DefaultDw
);

  logic          i_val;
  logic          o_rdy;
  logic [AW-1:0] i_addr;
  logic          i_flush;
  logic [DW-1:0] o_data;
  logic          o_err;
  logic          o_ar_val;
  logic          i_ar_rdy;
  logic [AW-1:0] o_ar_addr;
  logic          i_r_val;
  logic          o_r_rdy;
  logic [DW-1:0] i_r_data;
  logic          i_r_err;

  // Bridge side.
  modport slave (
    input  i_val, i_addr, i_flush, i_ar_rdy, i_r_val, i_r_data, i_r_err,
    output o_rdy, o_data, o_err, o_ar_val, o_ar_addr, o_r_rdy
  );

  // Environment side: fetch unit plus bus slave.
  modport master (
    output i_val, i_addr, i_flush, i_ar_rdy, i_r_val, i_r_data, i_r_err,
    input  o_rdy, o_data, o_err, o_ar_val, o_ar_addr, o_r_rdy
  );

endinterface

// File: rtl/ifu_ibus_bridge.sv
// Converts the fetch unit's req/ready handshake into a single-outstanding AR/R read,
// with flush support that discards the in-flight beat and refetches.
module ifu_ibus_bridge
  import ifu_ibus_bridge_pkg::*;
#(
  parameter int unsigned   AW  = DefaultAw,
  parameter int unsigned   DW  = DefaultDw,
  parameter logic [DW-1:0] NOP = DW'(NopWord)
) (
  input logic               clk,
  input logic               rst_n,
  ifu_ibus_bridge_if.slave  bus
);

  state_e        state_q, state_d;
  logic          drop_q, drop_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic          err_q, err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      drop_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    drop_d       = drop_q;
    addr_d       = addr_q;
    data_d       = data_q;
    err_d        = err_q;
    bus.o_rdy    = 1'b0;
    bus.o_ar_val = 1'b0;
    bus.o_r_rdy  = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.i_val) begin
          addr_d  = bus.i_addr;
          state_d = StAddr;
        end
      end
      StAddr: begin
        bus.o_ar_val = 1'b1;
        // The presented address must not change, so a flush is deferred to the data phase.
        if (bus.i_flush) drop_d = 1'b1;
        if (bus.i_ar_rdy) state_d = StData;
      end
      StData: begin
        bus.o_r_rdy = 1'b1;
        if (bus.i_r_val) begin
          if (drop_q || bus.i_flush) begin
            drop_d  = 1'b0;
            addr_d  = bus.i_addr;
            state_d = StAddr;
          end else begin
            data_d  = bus.i_r_err ? NOP : bus.i_r_data;
            err_d   = bus.i_r_err;
            state_d = StResp;
          end
        end else if (bus.i_flush) begin
          drop_d = 1'b1;
        end
      end
      StResp: begin
        bus.o_rdy = ~bus.i_flush;
        if (bus.i_flush || bus.i_val) begin
          addr_d  = bus.i_addr;
          state_d = StAddr;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.o_ar_addr = addr_q;
  assign bus.o_data    = data_q;
  assign bus.o_err     = err_q;

endmodule

// File: tb/tb_ifu_ibus_bridge.sv
// Directed bench for ifu_ibus_bridge with address and response scoreboards.
module tb_ifu_ibus_bridge;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ifu_ibus_bridge_if #(.AW(32), .DW(32)) bif ();

  ifu_ibus_bridge #(.AW(32), .DW(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  int checks = 0;
  int failures = 0;
  int cyc_cnt = 0;
  int last_rdy = 0;
  int prev_rdy = 0;
  logic [31:0] addr_q[$];
  logic [32:0] resp_q[$];  // {err, data}

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Monitor: every AR handshake and every o_rdy pulse must match a queued expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bif.o_ar_val && bif.i_ar_rdy) begin
        logic [31:0] ea;
        ea = (addr_q.size() != 0) ? addr_q.pop_front() : 32'hxxxx_xxxx;
        chk("ar_addr", bif.o_ar_addr, ea);
      end
      if (bif.o_rdy) begin
        logic [32:0] er;
        er = (resp_q.size() != 0) ? resp_q.pop_front() : 33'hx_xxxx_xxxx;
        chk("rdata", bif.o_data, er[31:0]);
        chk("rerr", {31'd0, bif.o_err}, {31'd0, er[32]});
        prev_rdy = last_rdy;
        last_rdy = cyc_cnt;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ar_handshake(input int stall);
    int n = 0;
    logic [31:0] a;
    while (!bif.o_ar_val && n < 20) begin
      step();
      n++;
    end
    chk("ar_wait", {31'd0, bif.o_ar_val}, 32'd1);
    a = bif.o_ar_addr;
    for (int s = 0; s < stall; s++) begin
      step();
      chk("ar_val_held", {31'd0, bif.o_ar_val}, 32'd1);
      chk("ar_addr_held", bif.o_ar_addr, a);
    end
    bif.i_ar_rdy = 1'b1;
    step();
    bif.i_ar_rdy = 1'b0;
  endtask

  task automatic r_beat(input int stall, input logic [31:0] d, input logic e, input bit expect_rdy);
    int n = 0;
    while (!bif.o_r_rdy && n < 20) begin
      step();
      n++;
    end
    chk("r_wait", {31'd0, bif.o_r_rdy}, 32'd1);
    for (int s = 0; s < stall; s++) begin
      step();
      chk("no_early_ar", {31'd0, bif.o_ar_val}, 32'd0);
    end
    bif.i_r_val  = 1'b1;
    bif.i_r_data = d;
    bif.i_r_err  = e;
    if (expect_rdy) resp_q.push_back({e, e ? 32'h0000_0013 : d});
    step();
    bif.i_r_val = 1'b0;
    bif.i_r_err = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bif.i_val    = 1'b0;
    bif.i_addr   = '0;
    bif.i_flush  = 1'b0;
    bif.i_ar_rdy = 1'b0;
    bif.i_r_val  = 1'b0;
    bif.i_r_data = '0;
    bif.i_r_err  = 1'b0;
    #1;
    chk("rst_rdy", {31'd0, bif.o_rdy}, 32'd0);
    chk("rst_ar_val", {31'd0, bif.o_ar_val}, 32'd0);
    chk("rst_r_rdy", {31'd0, bif.o_r_rdy}, 32'd0);
    chk("rst_ar_addr", bif.o_ar_addr, 32'd0);
    chk("rst_data", bif.o_data, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
    step();
    chk("idle_quiet", {31'd0, bif.o_ar_val}, 32'd0);

    // Zero-wait back-to-back fetches.
    bif.i_val  = 1'b1;
    bif.i_addr = 32'h8000_0000;
    addr_q.push_back(32'h8000_0000);
    step();
    ar_handshake(0);
    r_beat(0, 32'h0050_0093, 1'b0, 1'b1);
    bif.i_addr = 32'h8000_0004;
    addr_q.push_back(32'h8000_0004);
    ar_handshake(0);
    r_beat(0, 32'h0000_0013, 1'b0, 1'b1);
    bif.i_val = 1'b0;
    step();
    chk("rdy_spacing", last_rdy - prev_rdy, 32'd3);
    chk("back_to_idle", {31'd0, bif.o_ar_val}, 32'd0);

    // Stalled address and data phases.
    bif.i_val  = 1'b1;
    bif.i_addr = 32'h8000_0008;
    addr_q.push_back(32'h8000_0008);
    step();
    bif.i_val = 1'b0;
    ar_handshake(4);
    r_beat(5, 32'h1111_1111, 1'b0, 1'b1);
    step();

    // Flush in DATA: late beat is dropped, redirected PC fetched.
    bif.i_val  = 1'b1;
    bif.i_addr = 32'h8000_0010;
    addr_q.push_back(32'h8000_0010);
    step();
    bif.i_val = 1'b0;
    ar_handshake(0);
    bif.i_flush = 1'b1;
    bif.i_addr  = 32'h8000_0100;
    addr_q.push_back(32'h8000_0100);
    step();
    bif.i_flush = 1'b0;
    r_beat(1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    ar_handshake(0);
    r_beat(0, 32'hCAFE_F00D, 1'b0, 1'b1);
    step();

    // Beat and flush in the same cycle: immediate refetch.
    bif.i_val  = 1'b1;
    bif.i_addr = 32'h8000_0020;
    addr_q.push_back(32'h8000_0020);
    step();
    bif.i_val = 1'b0;
    ar_handshake(0);
    bif.i_flush = 1'b1;
    bif.i_addr  = 32'h8000_0200;
    addr_q.push_back(32'h8000_0200);
    r_beat(0, 32'hBAD0_BAD0, 1'b0, 1'b0);
    bif.i_flush = 1'b0;
    chk("refetch_ar_val", {31'd0, bif.o_ar_val}, 32'd1);
    chk("refetch_addr", bif.o_ar_addr, 32'h8000_0200);
    ar_handshake(0);
    r_beat(0, 32'h0000_0297, 1'b0, 1'b1);
    step();

    // Bus error substitutes the nop word.
    bif.i_val  = 1'b1;
    bif.i_addr = 32'h8000_0030;
    addr_q.push_back(32'h8000_0030);
    step();
    bif.i_val = 1'b0;
    ar_handshake(0);
    r_beat(0, 32'h1234_5678, 1'b1, 1'b1);
    chk("err_rdy", {31'd0, bif.o_rdy}, 32'd1);
    chk("err_flag", {31'd0, bif.o_err}, 32'd1);
    chk("err_nop", bif.o_data, 32'h0000_0013);
    step();

    // Flush in RESP suppresses o_rdy and refetches.
    bif.i_val  = 1'b1;
    bif.i_addr = 32'h8000_0060;
    addr_q.push_back(32'h8000_0060);
    step();
    bif.i_val = 1'b0;
    ar_handshake(0);
    r_beat(0, 32'h0000_0055, 1'b0, 1'b0);
    bif.i_flush = 1'b1;
    bif.i_addr  = 32'h8000_0300;
    addr_q.push_back(32'h8000_0300);
    #1;
    chk("resp_flush_rdy", {31'd0, bif.o_rdy}, 32'd0);
    step();
    bif.i_flush = 1'b0;
    ar_handshake(0);
    r_beat(0, 32'h0000_0066, 1'b0, 1'b1);
    step();

    // Asynchronous reset while in DATA.
    bif.i_val  = 1'b1;
    bif.i_addr = 32'h8000_0040;
    addr_q.push_back(32'h8000_0040);
    step();
    bif.i_val = 1'b0;
    ar_handshake(0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_r_rdy", {31'd0, bif.o_r_rdy}, 32'd0);
    chk("arst_ar_addr", bif.o_ar_addr, 32'd0);
    chk("arst_data", bif.o_data, 32'd0);
    chk("arst_err", {31'd0, bif.o_err}, 32'd0);
    step();
    rst_n = 1'b1;
    bif.i_val  = 1'b1;
    bif.i_addr = 32'h8000_0050;
    addr_q.push_back(32'h8000_0050);
    step();
    bif.i_val = 1'b0;
    ar_handshake(0);
    r_beat(0, 32'h0010_0073, 1'b0, 1'b1);
    step();
    step();

    chk("addr_q_empty", addr_q.size(), 32'd0);
    chk("resp_q_empty", resp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ifu_ibus_bridge.md
Name: ifu_ibus_bridge

Overview:
Upstream neighbour of the instruction-fetch unit. It converts the fetch unit's single-signal request/ready handshake into a split address/data read bus with variable latency (AR/R style), with one outstanding transaction. It returns the fetched word, plus an error flag, to the fetch unit. A flush input drops the in-flight word so that a redirected PC is fetched instead.

Parameters:
AW, 32, address width
DW, 32, instruction/data width
NOP, 32'h00000013, word driven on o_data when the bus reports an error

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous assert, active-low
i_val  in  1  fetch unit has a valid next-PC on i_addr
o_rdy  out  1  one-cycle pulse: o_data/o_err valid this cycle, and i_addr is accepted at this edge
i_addr  in  AW  next fetch address (fetch unit's pc_nx)
i_flush  in  1  discard the in-flight word and refetch from i_addr
o_data  out  DW  fetched instruction, registered
o_err  out  1  bus error for the word in o_data
o_ar_val  out  1  read address valid
i_ar_rdy  in  1  read address accepted
o_ar_addr  out  AW  read address, registered
i_r_val  in  1  read data valid
o_r_rdy  out  1  ready for read data
i_r_data  in  DW  read data
i_r_err  in  1  read error with data

Behaviour:
- Decided: single clock clk; rst_n is asynchronous, active-low.
- Reset values:
  - state = IDLE
  - o_rdy = 0, o_ar_val = 0, o_r_rdy = 0
  - o_ar_addr = 0, o_data = 0, o_err = 0
  - drop flag = 0
- FSM has four states: IDLE, ADDR, DATA, RESP.
- IDLE:
  - All bus outputs are 0.
  - If i_val: o_ar_addr <= i_addr, go to ADDR. This is the boot-time capture; it happens without o_rdy.
- ADDR:
  - o_ar_val = 1, and o_ar_addr is held stable.
  - On i_ar_rdy: go to DATA.
  - i_flush in ADDR: o_ar_addr <= i_addr and stay in ADDR. AXI-strict: an address already presented must not change, so a flush is instead recorded as drop = 1 and handled in DATA. Decided: record drop.
- DATA:
  - o_r_rdy = 1.
  - On i_r_val with drop = 0: o_data <= (i_r_err ? NOP : i_r_data), o_err <= i_r_err, go to RESP.
  - On i_r_val with drop = 1, or with i_flush in the same cycle: discard the beat, clear drop, o_ar_addr <= i_addr, go to ADDR.
  - i_flush without i_r_val: set drop = 1.
- RESP:
  - o_rdy = 1 for exactly one cycle.
  - If i_flush: o_rdy is suppressed (0), o_ar_addr <= i_addr, go to ADDR.
  - Else if i_val: o_ar_addr <= i_addr, go to ADDR.
  - Else go to IDLE.
- o_data and o_err hold their value until the next successful beat. They are valid only while o_rdy = 1.
- Latency: with a zero-wait bus (i_ar_rdy and i_r_val both 1 in the first eligible cycle), a fetch takes 3 cycles (ADDR, DATA, RESP). Sustained throughput is one word per 3 cycles.
- Only one transaction is ever outstanding. A new AR is never issued before the R beat for the previous AR has been consumed, including dropped beats.
- Reset mid-transaction: everything returns to IDLE immediately. The bus slave shares rst_n, so no orphan beat can arrive.
- i_val low in IDLE: remain idle indefinitely with no bus activity.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2, RESP = 2'd3
  - NOP constant
- No sub-module. State, address, data and drop registers use the codebase's existing reset/load flop cells.

Test Plan:
- Zero-wait bus, i_val = 1, i_addr = 0x80000000, then 0x80000004; slave returns 0x00500093 then 0x00000013 -> o_rdy pulses 3 cycles apart, o_data matches each word in order, o_ar_addr sequence is 0x80000000, 0x80000004.
- i_ar_rdy stalled 4 cycles and i_r_val stalled 5 cycles -> o_ar_val and o_ar_addr held stable throughout the stall; o_rdy pulses only after the beat; no second AR issued early.
- i_flush in DATA with i_addr = 0x80000100, slave later returns 0xDEADBEEF -> beat discarded, no o_rdy; next AR address is 0x80000100; its word is delivered with o_rdy.
- i_r_val and i_flush in the same cycle -> no o_rdy, immediate refetch from i_addr.
- Slave returns i_r_err = 1 with data 0x12345678 -> o_rdy = 1, o_err = 1, o_data = 0x00000013.
- rst_n asserted while in DATA -> outputs at reset values asynchronously; after release with i_val = 1, a fresh AR is issued from IDLE.
